// File: rtl/reg_window_ctrl.sv
// SPARC V8 register-window controller: CWP/WIM state, SAVE/RESTORE/RETT/trap moves, and a
// registered rs1/rs2/rd translation to physical indices. Define BANKED_GLOBALS_EN for banked globals.
module reg_window_ctrl #(
    parameter int NWIN  = 8,
    parameter int NGSET = 4,
    parameter int PAW   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            save,
    input  logic            restore,
    input  logic            rett,
    input  logic            trap_entry,
    input  logic            wr_cwp,
    input  logic [4:0]      cwp_in,
    input  logic            wr_wim,
    input  logic [NWIN-1:0] wim_in,
    input  logic [1:0]      gsel,
    input  logic [4:0]      addr_a,
    input  logic [4:0]      addr_b,
    input  logic [4:0]      addr_d,
    input  logic            addr_vld,
    output logic [PAW-1:0]  phys_a,
    output logic [PAW-1:0]  phys_b,
    output logic [PAW-1:0]  phys_d,
    output logic            phys_vld,
    output logic [4:0]      cwp,
    output logic [NWIN-1:0] wim,
    output logic            win_ovf,
    output logic            win_unf,
    output logic            win_err
);

`ifdef BANKED_GLOBALS_EN
    localparam int unsigned GBASE = 32'(8 * NGSET);
`else
    localparam int unsigned GBASE = 32'd8;
`endif
    localparam int unsigned WSPAN    = 32'(16 * NWIN);
    localparam logic [4:0]  CWP_LAST = 5'(NWIN - 1);

    logic [4:0]      cwp_q, cwp_d, cwp_dec, cwp_inc;
    logic [NWIN-1:0] wim_q, wim_d;
    logic [PAW-1:0]  phys_a_q, phys_b_q, phys_d_q;
    logic [PAW-1:0]  phys_a_d, phys_b_d, phys_d_d;
    logic [PAW-1:0]  goff;
    logic            vld_q;
    logic            ovf_q, ovf_d, unf_q, unf_d, err_q, err_d;
    logic            dec_hit, inc_hit, cwp_in_bad, gsel_bad;

    // Window offset wraps modulo the whole windowed span, so the ins of window w alias
    // the outs of window w+1 for any NWIN, including non-powers of two.
    function automatic logic [PAW-1:0] xlate(input logic [4:0] r, input logic [4:0] c,
                                             input logic [PAW-1:0] g);
        int unsigned off;
        if (r < 5'd8) return g + PAW'(r);
        off = (32'(c) * 32'd16 + 32'(r) - 32'd8) % WSPAN;
        return PAW'(GBASE + off);
    endfunction

`ifdef BANKED_GLOBALS_EN
    assign gsel_bad = (32'(gsel) >= 32'(NGSET));
    assign goff     = gsel_bad ? '0 : PAW'({gsel, 3'b000});
`else
    logic unused_gsel;
    assign unused_gsel = ^gsel;
    assign gsel_bad    = 1'b0;
    assign goff        = '0;
`endif

    assign cwp_dec    = (cwp_q == 5'd0) ? CWP_LAST : cwp_q - 5'd1;
    assign cwp_inc    = (cwp_q == CWP_LAST) ? 5'd0 : cwp_q + 5'd1;
    assign dec_hit    = |(wim_q & (NWIN'(1) << cwp_dec));
    assign inc_hit    = |(wim_q & (NWIN'(1) << cwp_inc));
    assign cwp_in_bad = (32'(cwp_in) >= 32'(NWIN));

    // NOTE: every variable gets a default before the priority chain so no latch is inferred.
    always_comb begin
        cwp_d = cwp_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        err_d = 1'b0;
        if (trap_entry) begin
            cwp_d = cwp_dec;
        end else if (rett || (restore && !save)) begin
            if (inc_hit) unf_d = 1'b1;
            else         cwp_d = cwp_inc;
        end else if (save && restore) begin
            err_d = 1'b1;
        end else if (save) begin
            if (dec_hit) ovf_d = 1'b1;
            else         cwp_d = cwp_dec;
        end else if (wr_cwp) begin
            if (cwp_in_bad) err_d = 1'b1;
            else            cwp_d = cwp_in;
        end
        if (addr_vld && gsel_bad) err_d = 1'b1;
        wim_d    = wr_wim ? wim_in : wim_q;
        // Translation uses the pre-edge CWP; a same-cycle move affects the next lookup.
        phys_a_d = xlate(addr_a, cwp_q, goff);
        phys_b_d = xlate(addr_b, cwp_q, goff);
        phys_d_d = xlate(addr_d, cwp_q, goff);
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cwp_q    <= '0;
            wim_q    <= '0;
            phys_a_q <= '0;
            phys_b_q <= '0;
            phys_d_q <= '0;
            vld_q    <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cwp_q    <= cwp_d;
            wim_q    <= wim_d;
            phys_a_q <= phys_a_d;
            phys_b_q <= phys_b_d;
            phys_d_q <= phys_d_d;
            vld_q    <= addr_vld;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            err_q    <= err_d;
        end
    end

    assign cwp      = cwp_q;
    assign wim      = wim_q;
    assign phys_a   = phys_a_q;
    assign phys_b   = phys_b_q;
    assign phys_d   = phys_d_q;
    assign phys_vld = vld_q;
    assign win_ovf  = ovf_q;
    assign win_unf  = unf_q;
    assign win_err  = err_q;

endmodule

// File: tb/tb_reg_window_ctrl.sv
// Self-checking bench for reg_window_ctrl: directed corner cases with literal expectations,
// then randomized traffic compared every cycle against a behavioural window model.
module tb_reg_window_ctrl;
    localparam int NWIN  = 8;
    localparam int NGSET = 4;
    localparam int PAW   = 8;
`ifdef BANKED_GLOBALS_EN
    localparam int GBASE = 8 * NGSET;
`else
    localparam int GBASE = 8;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            save = 0, restore = 0, rett = 0, trap_entry = 0, wr_cwp = 0, wr_wim = 0;
    logic [4:0]      cwp_in = '0;
    logic [NWIN-1:0] wim_in = '0;
    logic [1:0]      gsel = '0;
    logic [4:0]      addr_a = '0, addr_b = '0, addr_d = '0;
    logic            addr_vld = 1'b0;
    logic [PAW-1:0]  phys_a, phys_b, phys_d;
    logic            phys_vld, win_ovf, win_unf, win_err;
    logic [4:0]      cwp;
    logic [NWIN-1:0] wim;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    // Reference state and expected outputs.
    int              m_cwp = 0;
    logic [NWIN-1:0] m_wim = '0;
    int              e_pa = 0, e_pb = 0, e_pd = 0;
    bit              e_vld = 0, e_ovf = 0, e_unf = 0, e_err = 0;
    int              old_cwp, dn, up;
    logic [NWIN-1:0] old_wim;

    reg_window_ctrl #(.NWIN(NWIN), .NGSET(NGSET), .PAW(PAW)) dut (
        .clk(clk), .rst_n(rst_n), .save(save), .restore(restore), .rett(rett),
        .trap_entry(trap_entry), .wr_cwp(wr_cwp), .cwp_in(cwp_in), .wr_wim(wr_wim),
        .wim_in(wim_in), .gsel(gsel), .addr_a(addr_a), .addr_b(addr_b), .addr_d(addr_d),
        .addr_vld(addr_vld), .phys_a(phys_a), .phys_b(phys_b), .phys_d(phys_d),
        .phys_vld(phys_vld), .cwp(cwp), .wim(wim), .win_ovf(win_ovf), .win_unf(win_unf),
        .win_err(win_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int xl(input int r, input int c, input int g);
        if (r < 8) begin
`ifdef BANKED_GLOBALS_EN
            return ((g < NGSET) ? g : 0) * 8 + r;
`else
            return r + 0 * g;
`endif
        end
        return GBASE + (c * 16 + r - 8) % (16 * NWIN);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cwp = 0; m_wim = '0;
            e_pa = 0; e_pb = 0; e_pd = 0;
            e_vld = 0; e_ovf = 0; e_unf = 0; e_err = 0;
        end else begin
            old_cwp = m_cwp;
            old_wim = m_wim;
            e_pa  = xl(int'(addr_a), old_cwp, int'(gsel));
            e_pb  = xl(int'(addr_b), old_cwp, int'(gsel));
            e_pd  = xl(int'(addr_d), old_cwp, int'(gsel));
            e_vld = addr_vld;
            e_ovf = 0; e_unf = 0; e_err = 0;
            dn = (old_cwp + NWIN - 1) % NWIN;
            up = (old_cwp + 1) % NWIN;
            if (trap_entry)                   m_cwp = dn;
            else if (rett || (restore && !save)) begin
                if (old_wim[up]) e_unf = 1; else m_cwp = up;
            end
            else if (save && restore)         e_err = 1;
            else if (save) begin
                if (old_wim[dn]) e_ovf = 1; else m_cwp = dn;
            end
            else if (wr_cwp) begin
                if (int'(cwp_in) >= NWIN) e_err = 1; else m_cwp = int'(cwp_in);
            end
            if (wr_wim) m_wim = wim_in;
`ifdef BANKED_GLOBALS_EN
            if (addr_vld && int'(gsel) >= NGSET) e_err = 1;
`endif
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cwp",      32'(cwp),      32'(m_cwp));
            check("wim",      32'(wim),      32'(m_wim));
            check("phys_a",   32'(phys_a),   32'(e_pa));
            check("phys_b",   32'(phys_b),   32'(e_pb));
            check("phys_d",   32'(phys_d),   32'(e_pd));
            check("phys_vld", 32'(phys_vld), 32'(e_vld));
            check("win_ovf",  32'(win_ovf),  32'(e_ovf));
            check("win_unf",  32'(win_unf),  32'(e_unf));
            check("win_err",  32'(win_err),  32'(e_err));
        end
    end

    task automatic idle();
        save = 0; restore = 0; rett = 0; trap_entry = 0; wr_cwp = 0; wr_wim = 0;
        addr_vld = 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cwp(input int v);
        wr_cwp = 1; cwp_in = 5'(v); cycle(); idle();
    endtask

    task automatic set_wim(input int v);
        wr_wim = 1; wim_in = NWIN'(v); cycle(); idle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        cycle(); cycle();
        check("rst_cwp", 32'(cwp), 0);
        check("rst_vld", 32'(phys_vld), 0);
        check("rst_pulses", 32'({win_ovf, win_unf, win_err}), 0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Reach cwp=5 with a valid translation, then reset between edges.
        addr_vld = 1; addr_a = 5'd9;
        set_cwp(5);
        check("pre_rst_cwp", 32'(cwp), 5);
        check("pre_rst_vld", 32'(phys_vld), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_cwp", 32'(cwp), 0);
        check("async_wim", 32'(wim), 0);
        check("async_vld", 32'(phys_vld), 0);
        check("async_pulses", 32'({win_ovf, win_unf, win_err}), 0);
        cycle();
        rst_n = 1'b1;

        // Overflow at wrap, then wrap with no invalid window.
        set_wim(8'h80);
        save = 1; cycle(); idle();
        check("ovf_pulse", 32'(win_ovf), 1);
        check("ovf_cwp", 32'(cwp), 0);
        cycle();
        check("ovf_one_cycle", 32'(win_ovf), 0);
        set_wim(0);
        save = 1; cycle(); idle();
        check("wrap_save_cwp", 32'(cwp), 7);

        // Underflow at cwp=7, then rett wraps to 0.
        set_wim(8'h01);
        restore = 1; cycle(); idle();
        check("unf_pulse", 32'(win_unf), 1);
        check("unf_cwp", 32'(cwp), 7);
        set_wim(0);
        rett = 1; cycle(); idle();
        check("rett_wrap_cwp", 32'(cwp), 0);

        // Translation at cwp=7.
        set_cwp(7);
        addr_vld = 1; addr_a = 5'd24; addr_b = 5'd8; addr_d = 5'd3; cycle(); idle();
        check("xl_vld", 32'(phys_vld), 1);
`ifndef BANKED_GLOBALS_EN
        check("xl_a", 32'(phys_a), 8);
        check("xl_b", 32'(phys_b), 120);
        check("xl_d", 32'(phys_d), 3);
`endif
        cycle();
        check("xl_vld_drop", 32'(phys_vld), 0);

        // Priority and illegal combinations.
        set_cwp(2);
        set_wim(8'h02);
        trap_entry = 1; save = 1; cycle(); idle();
        check("trap_cwp", 32'(cwp), 1);
        check("trap_no_ovf", 32'(win_ovf), 0);
        set_wim(0);
        save = 1; restore = 1; cycle(); idle();
        check("sr_err", 32'(win_err), 1);
        check("sr_cwp", 32'(cwp), 1);
        wr_cwp = 1; cwp_in = 5'd9; cycle(); idle();
        check("wrcwp_err", 32'(win_err), 1);
        check("wrcwp_cwp", 32'(cwp), 1);

`ifdef BANKED_GLOBALS_EN
        set_cwp(0);
        gsel = 2'd2; addr_vld = 1; addr_a = 5'd5; addr_b = 5'd16; cycle(); idle();
        check("bank_a", 32'(phys_a), 21);
        check("bank_b", 32'(phys_b), 40);
        gsel = 2'd3; addr_vld = 1; addr_a = 5'd0; cycle(); idle();
        check("bank3_a", 32'(phys_a), 24);
`endif

        // Randomized traffic; the compare process checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            trap_entry = ($urandom_range(0, 19) == 0);
            rett       = ($urandom_range(0, 19) == 0);
            save       = ($urandom_range(0, 3) == 0);
            restore    = ($urandom_range(0, 3) == 0);
            wr_cwp     = ($urandom_range(0, 9) == 0);
            cwp_in     = 5'($urandom_range(0, 15));
            wr_wim     = ($urandom_range(0, 9) == 0);
            wim_in     = NWIN'($urandom & $urandom);
            gsel       = 2'($urandom);
            addr_a     = 5'($urandom);
            addr_b     = 5'($urandom);
            addr_d     = 5'($urandom);
            addr_vld   = ($urandom_range(0, 9) < 7);
            cycle();
        end
        idle();
        cycle(); cycle();
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/reg_window_ctrl.md
Name: reg_window_ctrl

Overview:
- Parametrised register-window controller for the SPARC V8 register file; successor to the fixed 4-window global-register select.
- Holds CWP and WIM and executes SAVE/RESTORE/RETT/trap-entry window moves with overflow/underflow detection.
- Translates three architectural register addresses (rs1, rs2, rd) to physical register-file indices through a registered stage.
- Sits between the instruction decoder and the physical register file.

Parameters:
- NWIN, 8, number of register windows (2..32).
- NGSET, 4, number of global register banks; used only when BANKED_GLOBALS_EN is defined.
- PAW, 8, physical index width. Must satisfy 2^PAW >= GBASE + 16*NWIN, where GBASE = 8 (no banking) or 8*NGSET (with banking).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- save  in  1  SAVE request, single-cycle pulse.
- restore  in  1  RESTORE request.
- rett  in  1  RETT request.
- trap_entry  in  1  trap taken; decrement CWP without a WIM check.
- wr_cwp  in  1  write CWP from PSR.
- cwp_in  in  5  new CWP value.
- wr_wim  in  1  write WIM.
- wim_in  in  NWIN  new WIM value.
- gsel  in  2  global bank select; ignored unless BANKED_GLOBALS_EN is defined.
- addr_a  in  5  rs1 architectural register.
- addr_b  in  5  rs2 architectural register.
- addr_d  in  5  rd architectural register.
- addr_vld  in  1  addresses valid.
- phys_a  out  PAW  translated rs1.
- phys_b  out  PAW  translated rs2.
- phys_d  out  PAW  translated rd.
- phys_vld  out  1  translation valid.
- cwp  out  5  current window pointer.
- wim  out  NWIN  window invalid mask.
- win_ovf  out  1  window overflow trap, 1-cycle pulse.
- win_unf  out  1  window underflow trap, 1-cycle pulse.
- win_err  out  1  illegal request combination or out-of-range CWP write, 1-cycle pulse.

Behaviour:
- Reset (async, rst_n=0): cwp=0, wim=0, phys_a/b/d=0, phys_vld=0, win_ovf=win_unf=win_err=0. These hold until the first rising clk after release.
- Window moves are evaluated on each rising edge, one per cycle, with priority trap_entry > rett > save/restore > wr_cwp.
- trap_entry: cwp <= (cwp-1) mod NWIN. No WIM check. Other window requests in the same cycle are dropped.
- save: nxt = (cwp-1) mod NWIN.
  - wim[nxt]=1: win_ovf pulses next cycle and cwp is unchanged.
  - Otherwise: cwp <= nxt.
- restore and rett: nxt = (cwp+1) mod NWIN.
  - wim[nxt]=1: win_unf pulses and cwp is unchanged.
  - Otherwise: cwp <= nxt.
- save and restore asserted together: neither executes; win_err pulses.
- wr_cwp:
  - cwp_in >= NWIN: cwp unchanged; win_err pulses.
  - Otherwise: cwp <= cwp_in.
- wr_wim: wim <= wim_in, independent of the window-move priority. A WIM write in the same cycle as a save/restore does not affect that cycle's check, which uses the old wim.
- Wrap-around: cwp=0 with save goes to NWIN-1; cwp=NWIN-1 with restore goes to 0.
- Translation latency is exactly 1 cycle. phys_vld <= addr_vld. Addresses are translated with the cwp value present before the edge, so a same-cycle window move affects the next translation, not this one.
- Translation for r < 8 (globals): phys = r.
- Translation for r >= 8: phys = GBASE + ((cwp*16 + r - 8) mod (16*NWIN)). This makes the ins (r24..31) of window w the outs (r8..15) of window w+1.
- Arithmetic uses full-width intermediates; the modulo is a true modulo for non-power-of-two NWIN.
- Addresses are registered even when addr_vld=0, to keep the datapath simple.

Optional Feature:
- Macro: BANKED_GLOBALS_EN.
- Defined: globals are banked. For r < 8, phys = gsel*8 + r, and GBASE = 8*NGSET. gsel >= NGSET is treated as 0, and win_err pulses when addr_vld=1.
- Undefined: gsel is ignored, GBASE = 8, and a single global bank maps to phys 0..7.

Test Plan:
- Reset mid-operation: NWIN=8; reach cwp=5, then drop rst_n asynchronously between edges. cwp=0, wim=0, phys_vld=0 immediately; no pulses.
- Wrap and overflow:
  - cwp=0, wim=0x80, save: win_ovf=1 one cycle, cwp stays 0.
  - Same with wim=0x00: cwp=7.
- Underflow: cwp=7, wim=0x01, restore: win_unf=1, cwp=7. rett with wim=0: cwp=0.
- Translation at cwp=7, addr_vld=1: addr_a=24 -> phys_a=8; addr_b=8 -> phys_b=120; addr_d=3 -> phys_d=3; phys_vld one cycle later.
- Priority and illegal combinations:
  - trap_entry+save at cwp=2: cwp=1, no win_ovf.
  - save+restore together: win_err=1, cwp unchanged.
  - wr_cwp cwp_in=9: win_err=1, cwp unchanged.
- BANKED_GLOBALS_EN defined, NGSET=4, gsel=2:
  - addr_a=5 -> phys_a=21.
  - addr_b=16 at cwp=0 -> phys_b=40.
  - gsel=3, addr_a=0 -> phys_a=24.
